// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg: shared defaults and select-width helper for the stream demultiplexer.
// Revision 1.0
`default_nettype none

package stream_demux_pkg;

  localparam int DEFAULT_DATAWIDTH = 8;
  localparam int DEFAULT_NUM_OUT   = 4;

  // Select width is clog2 of the channel count, never narrower than one bit.
  function automatic int calc_selw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/stream_slot.sv
// stream_slot: single-entry registered buffer (full flag plus data) for one demux channel.
// Revision 1.0
`default_nettype none

module stream_slot #(
  parameter int DATAWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATAWIDTH-1:0] din,
  output logic [DATAWIDTH-1:0] dout,
  output logic                 full
);

  logic                 r_full;
  logic [DATAWIDTH-1:0] r_data;

  // A push wins over a simultaneous pop so the slot is refilled without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (push) begin
      r_full <= 1'b1;
      r_data <= din;
    end else if (pop) begin
      r_full <= 1'b0;
    end
  end

  assign full = r_full;
  assign dout = r_data;

endmodule

`default_nettype wire

// File: rtl/stream_demux.sv
// stream_demux: routes one input stream to NUM_OUT single-slot output channels by select index.
// Revision 1.0
`default_nettype none

module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int DATAWIDTH = DEFAULT_DATAWIDTH,
  parameter int NUM_OUT   = DEFAULT_NUM_OUT
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [DATAWIDTH-1:0]                in_data,
  input  logic [calc_selw(NUM_OUT)-1:0]       in_sel,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic [NUM_OUT-1:0][DATAWIDTH-1:0]   out_data,
  output logic [NUM_OUT-1:0]                  out_valid,
  input  logic [NUM_OUT-1:0]                  out_ready,
  output logic                                err_sel
);

  localparam int SELW    = calc_selw(NUM_OUT);
  localparam int SELSPAN = 1 << SELW;

  logic [NUM_OUT-1:0] w_full;
  logic [NUM_OUT-1:0] w_push;
  logic [NUM_OUT-1:0] w_pop;
  logic [SELSPAN-1:0] w_accept_ok;
  logic               w_sel_ok;
  logic               w_in_fire;
  logic               r_err_sel;

  assign w_sel_ok  = (32'(in_sel) < 32'(NUM_OUT));
  assign in_ready  = w_accept_ok[in_sel];
  assign w_in_fire = in_valid & in_ready;

  genvar k;
  generate
    for (k = 0; k < NUM_OUT; k++) begin : g_slot
      assign w_accept_ok[k] = ~w_full[k] | out_ready[k];
      assign w_push[k]      = w_in_fire & (in_sel == SELW'(k));
      assign w_pop[k]       = w_full[k] & out_ready[k];

      stream_slot #(
        .DATAWIDTH (DATAWIDTH)
      ) u_slot (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push[k]),
        .pop   (w_pop[k]),
        .din   (in_data),
        .dout  (out_data[k]),
        .full  (w_full[k])
      );
    end

    // Unused select codes always accept so out-of-range payloads drain and get flagged.
    for (k = NUM_OUT; k < SELSPAN; k++) begin : g_pad
      assign w_accept_ok[k] = 1'b1;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_sel <= 1'b0;
    end else begin
      r_err_sel <= w_in_fire & ~w_sel_ok;
    end
  end

  assign out_valid = w_full;
  assign err_sel   = r_err_sel;

endmodule

`default_nettype wire

// File: tb/tb_stream_demux.sv
// tb_stream_demux: directed and randomized self-checking bench for stream_demux.
// Revision 1.0
`default_nettype none

module tb_stream_demux;

  logic            clk;
  logic            rst_n;
  logic [7:0]      in_data;
  logic [1:0]      in_sel;
  logic            in_valid;
  logic            in_ready;
  logic [3:0][7:0] out_data;
  logic [3:0]      out_valid;
  logic [3:0]      out_ready;
  logic            err_sel;

  logic [7:0]      in_data3;
  logic [1:0]      in_sel3;
  logic            in_valid3;
  logic            in_ready3;
  logic [2:0][7:0] out_data3;
  logic [2:0]      out_valid3;
  logic [2:0]      out_ready3;
  logic            err_sel3;

  int n_chk  = 0;
  int n_pass = 0;

  stream_demux #(.DATAWIDTH(8), .NUM_OUT(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_sel   (err_sel)
  );

  stream_demux #(.DATAWIDTH(8), .NUM_OUT(3)) u_dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data3),
    .in_sel    (in_sel3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .out_data  (out_data3),
    .out_valid (out_valid3),
    .out_ready (out_ready3),
    .err_sel   (err_sel3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: each channel is a FIFO of at most one pending payload.
  logic [7:0] pend [4][$];

  initial begin
    int sent, recv, tput, cyc;
    logic exp_rdy;

    rst_n = 1'b1;
    in_data = '0; in_sel = '0; in_valid = 1'b0; out_ready = '0;
    in_data3 = '0; in_sel3 = '0; in_valid3 = 1'b0; out_ready3 = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 4'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_err_sel", err_sel, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;

    // Single payload with every channel ready.
    out_ready = 4'hF; in_valid = 1'b1; in_sel = 2'd2; in_data = 8'hA5;
    #1 chk("a5_in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("a5_out_valid", out_valid, 4'b0100);
    chk("a5_out_data", out_data[2], 8'hA5);
    tick();
    chk("a5_cleared", out_valid, 4'b0000);

    // Stall channel 1 behind 0x11, then route 0x33 past the stall.
    out_ready = 4'b1101; in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h11;
    #1 chk("s11_in_ready", in_ready, 1'b1);
    tick();
    in_data = 8'h22;
    #1 chk("s22_blocked", in_ready, 1'b0);
    chk("s11_held_data", out_data[1], 8'h11);
    tick();
    chk("s22_still_blocked", in_ready, 1'b0);
    chk("s11_still_valid", out_valid, 4'b0010);
    in_sel = 2'd3; in_data = 8'h33;
    #1 chk("s33_in_ready", in_ready, 1'b1);
    tick();
    chk("s33_out_valid", out_valid, 4'b1010);
    chk("s33_out_data", out_data[3], 8'h33);
    chk("s11_stable", out_data[1], 8'h11);
    in_sel = 2'd1; in_data = 8'h22; out_ready = 4'hF;
    #1 chk("s22_released", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("s22_out_valid", out_valid, 4'b0010);
    chk("s22_out_data", out_data[1], 8'h22);
    tick();
    chk("s22_drained", out_valid, 4'b0000);

    // Out-of-range select on the three-channel instance.
    out_ready3 = 3'b111; in_valid3 = 1'b1; in_sel3 = 2'd3; in_data3 = 8'h7F;
    #1 chk("oor_in_ready", in_ready3, 1'b1);
    tick();
    in_valid3 = 1'b0;
    chk("oor_err_pulse", err_sel3, 1'b1);
    chk("oor_out_valid", out_valid3, 3'b000);
    tick();
    chk("oor_err_clear", err_sel3, 1'b0);
    chk("oor_out_valid2", out_valid3, 3'b000);

    // Fill all slots, then reset asynchronously between edges.
    out_ready = 4'h0; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_sel = 2'(k); in_data = 8'hC0 + 8'(k);
      tick();
    end
    in_valid = 1'b0;
    #1 chk("fill_out_valid", out_valid, 4'hF);
    chk("fill_out_data", out_data, 32'hC3C2C1C0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 4'h0);
    chk("arst_out_data", out_data, 32'h0);
    in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h01; out_ready = 4'hF;
    #1 rst_n = 1'b1;
    #1 chk("post_rst_in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("post_rst_out_valid", out_valid, 4'b0001);
    chk("post_rst_out_data", out_data[0], 8'h01);
    tick();
    chk("post_rst_drained", out_valid, 4'h0);

    // Randomized traffic against the per-channel queue model.
    sent = 0; recv = 0; tput = 0; cyc = 0;
    while (sent < 1000 && cyc < 20000) begin
      in_valid  = ($urandom_range(0, 9) != 0);
      in_sel    = 2'($urandom_range(0, 3));
      in_data   = 8'($urandom);
      out_ready = 4'($urandom);
      #1;
      exp_rdy = (pend[in_sel].size() == 0) || out_ready[in_sel];
      chk("rnd_in_ready", in_ready, exp_rdy);
      for (int k = 0; k < 4; k++) begin
        chk("rnd_out_valid", out_valid[k], pend[k].size() != 0);
        if (pend[k].size() != 0) chk("rnd_out_data", out_data[k], pend[k][0]);
      end
      for (int k = 0; k < 4; k++) begin
        if (pend[k].size() != 0 && out_ready[k]) begin
          void'(pend[k].pop_front());
          recv++;
        end
      end
      if (in_valid && exp_rdy) begin
        if (out_valid[in_sel] && out_ready[in_sel]) tput++;
        pend[in_sel].push_back(in_data);
        sent++;
      end
      tick();
      cyc++;
    end
    chk("rnd_sent", sent, 1000);
    chk("rnd_full_tput_seen", tput > 0, 1'b1);

    in_valid = 1'b0; out_ready = 4'hF;
    #1;
    for (int k = 0; k < 4; k++) begin
      if (pend[k].size() != 0) begin
        chk("drain_out_data", out_data[k], pend[k][0]);
        void'(pend[k].pop_front());
        recv++;
      end
    end
    tick();
    chk("drain_out_valid", out_valid, 4'h0);
    chk("drain_recv_count", recv, 1000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 The block SHALL have parameter DATAWIDTH, default 8, payload width in bits.
REQ-002 The block SHALL have parameter NUM_OUT, default 4, number of output channels (2..16).
REQ-003 The block SHALL use SELW = max(1, clog2(NUM_OUT)) as the select width.
REQ-004 Port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port in_data, input, DATAWIDTH, input payload.
REQ-007 Port in_sel, input, SELW, destination channel index for in_data.
REQ-008 Port in_valid, input, 1, input payload and select are valid.
REQ-009 Port in_ready, output, 1, block accepts input this cycle.
REQ-010 Port out_data, output, NUM_OUT x DATAWIDTH packed array, per-channel payload.
REQ-011 Port out_valid, output, NUM_OUT, per-channel payload valid.
REQ-012 Port out_ready, input, NUM_OUT, per-channel downstream ready.
REQ-013 Port err_sel, output, 1, one-cycle pulse when an out-of-range select is accepted.

Function
REQ-014 Transfer rules: an input transfer occurs when in_valid and in_ready are both high; an output transfer on channel k occurs when out_valid[k] and out_ready[k] are both high.
REQ-015 Each channel SHALL hold exactly one registered slot (full flag plus DATAWIDTH data register).
REQ-016 in_ready SHALL be combinational: high when in_sel is out of range, or when slot[in_sel] is empty, or when out_ready[in_sel] is high; it SHALL NOT depend on in_valid.
REQ-017 An accepted in-range payload SHALL appear on out_data[in_sel] with out_valid[in_sel] high on the next cycle (latency 1).
REQ-018 out_valid[k] SHALL equal full[k]; out_data[k] SHALL remain stable while out_valid[k] is high and out_ready[k] is low.
REQ-019 Simultaneous pop and push on the same full channel SHALL replace the slot contents in one cycle; full stays high; no bubble.
REQ-020 Pop on channel k with push to channel j != k in the same cycle SHALL proceed independently.
REQ-021 A full channel with out_ready low SHALL stall only inputs addressed to it; inputs to other channels SHALL still be accepted.
REQ-022 Out-of-range in_sel (>= NUM_OUT) SHALL be accepted and discarded, asserting err_sel for exactly one cycle after acceptance; no slot changes.
REQ-023 Order SHALL be preserved per channel; no ordering guarantee across channels.
REQ-024 out_data[k] SHALL retain its last value when empty; consumers SHALL ignore it while out_valid[k] is low.

Reset
REQ-025 While rst_n is low, all full flags, out_valid and err_sel SHALL be 0, and out_data SHALL be all zeros.
REQ-026 Reset asserted mid-operation SHALL discard all buffered payloads immediately, with no completion of a pending transfer.
REQ-027 The first input SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-028 Package stream_demux_pkg SHALL hold the SELW computation function and the default DATAWIDTH/NUM_OUT constants.
REQ-029 The per-channel slot SHALL be a sub-module, stream_slot, instantiated NUM_OUT times with a generate loop.
REQ-030 stream_slot SHALL have ports clk, rst_n, push, pop, din, dout and full.

Verification
REQ-031 Send 0xA5 to sel=2 with all out_ready=1: out_valid=4'b0100 and out_data[2]=0xA5 one cycle later, then cleared the following cycle.
REQ-032 Hold out_ready[1]=0; send 0x11 then 0x22 to sel=1: 0x11 is held; in_ready=0 for 0x22 until out_ready[1]=1, then 0x22 follows back-to-back.
REQ-033 Keep channel 1 stalled while sending 0x33 to sel=3: 0x33 is accepted and delivered at latency 1, unaffected by the stall.
REQ-034 With NUM_OUT=3, send sel=3 with data 0x7F: accepted, err_sel pulses once, all out_valid stay 0.
REQ-035 Load all four slots, then pulse rst_n low mid-cycle: out_valid=0 and out_data=0 asynchronously; after release, 0x01 to sel=0 arrives normally.
REQ-036 Send 1000 random payloads/selects under random out_ready: the scoreboard shows per-channel order preserved, zero loss and no duplicates; full-throughput cycles are observed.
